// File: rtl/serial_parity_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_parity_framer
// Brief    : Serial framer that generates or checks one parity bit per frame
//            of WORD_BITS data bits. Optional error counter: PARITY_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_framer #(
    parameter int WORD_BITS  = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_BITS   = 8
) (
    input  logic                           clk_2,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           mode,
    input  logic                           in_valid,
    input  logic                           in_bit,
    output logic                           busy,
    output logic [$clog2(WORD_BITS+1)-1:0] bit_count,
    output logic                           run_parity,
    output logic                           par_valid,
    output logic                           par_bit,
    output logic                           frame_done,
    output logic                           parity_err,
    output logic [CNT_BITS-1:0]            err_count
);

    localparam int              c_CW   = $clog2(WORD_BITS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WORD_BITS);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic            c_ODD  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CHKPAR = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_acc, w_acc_next;
    logic [c_CW-1:0]   r_bit_count, w_cnt_next;
    logic              r_mode, w_mode_next;
    logic              r_par_valid, w_par_valid_next;
    logic              r_par_bit, w_par_bit_next;
    logic              r_frame_done, w_frame_done_next;
    logic              r_parity_err, w_parity_err_next;

    logic              w_idle;
    logic              w_acc_bit;
    logic [c_CW-1:0]   w_cnt_bit;
    logic              w_mode_eff;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_acc        <= 1'b0;
            r_bit_count  <= '0;
            r_mode       <= 1'b0;
            r_par_valid  <= 1'b0;
            r_par_bit    <= 1'b0;
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_bit_count  <= w_cnt_next;
            r_mode       <= w_mode_next;
            r_par_valid  <= w_par_valid_next;
            r_par_bit    <= w_par_bit_next;
            r_frame_done <= w_frame_done_next;
            r_parity_err <= w_parity_err_next;
        end
    end

    // In IDLE the incoming bit starts a fresh frame, so the accumulator and
    // counter restart from zero and mode is taken live rather than latched.
    always_comb begin
        w_idle            = (r_state == S_IDLE);
        w_acc_bit         = (w_idle ? 1'b0 : r_acc) ^ in_bit;
        w_cnt_bit         = (w_idle ? '0 : r_bit_count) + c_ONE;
        w_mode_eff        = w_idle ? mode : r_mode;

        w_state_next      = r_state;
        w_acc_next        = r_acc;
        w_cnt_next        = r_bit_count;
        w_mode_next       = r_mode;
        w_par_valid_next  = 1'b0;
        w_par_bit_next    = 1'b0;
        w_frame_done_next = 1'b0;
        w_parity_err_next = 1'b0;

        if (clear) begin
            w_state_next = S_IDLE;
            w_acc_next   = 1'b0;
            w_cnt_next   = '0;
        end else if (in_valid) begin
            case (r_state)
                S_IDLE, S_DATA: begin
                    w_mode_next = w_mode_eff;
                    if (w_cnt_bit == c_LAST) begin
                        if (!w_mode_eff) begin
                            w_state_next      = S_IDLE;
                            w_acc_next        = 1'b0;
                            w_cnt_next        = '0;
                            w_par_valid_next  = 1'b1;
                            w_par_bit_next    = w_acc_bit ^ c_ODD;
                            w_frame_done_next = 1'b1;
                        end else begin
                            w_state_next = S_CHKPAR;
                            w_acc_next   = w_acc_bit;
                            w_cnt_next   = c_LAST;
                        end
                    end else begin
                        w_state_next = S_DATA;
                        w_acc_next   = w_acc_bit;
                        w_cnt_next   = w_cnt_bit;
                    end
                end
                S_CHKPAR: begin
                    w_state_next      = S_IDLE;
                    w_acc_next        = 1'b0;
                    w_cnt_next        = '0;
                    w_frame_done_next = 1'b1;
                    w_parity_err_next = r_acc ^ in_bit ^ c_ODD;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_acc_next   = 1'b0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign bit_count  = r_bit_count;
    assign run_parity = r_acc;
    assign par_valid  = r_par_valid;
    assign par_bit    = r_par_bit;
    assign frame_done = r_frame_done;
    assign parity_err = r_parity_err;

`ifdef PARITY_ERR_CNT_EN
    // Counts on the same edge that raises parity_err, so both are visible together.
    logic [CNT_BITS-1:0] r_err_count;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (w_parity_err_next && (r_err_count != {CNT_BITS{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_framer
// Brief    : Scoreboard bench; an even-parity and an odd-parity instance share
//            one random stimulus stream and are checked against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_framer;

    localparam int WB = 8;
    localparam int CB = 8;
    localparam int CW = $clog2(WB + 1);

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic reset_n, clear, mode, in_valid, in_bit;

    logic          busy0, busy1, rp0, rp1, pv0, pv1, pb0, pb1, fd0, fd1, pe0, pe1;
    logic [CW-1:0] bc0, bc1;
    logic [CB-1:0] ec0, ec1;

    serial_parity_framer #(.WORD_BITS(WB), .ODD_PARITY(0), .CNT_BITS(CB)) u_even (
        .clk_2(clk_2), .reset_n(reset_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_bit(in_bit), .busy(busy0), .bit_count(bc0),
        .run_parity(rp0), .par_valid(pv0), .par_bit(pb0), .frame_done(fd0),
        .parity_err(pe0), .err_count(ec0)
    );

    serial_parity_framer #(.WORD_BITS(WB), .ODD_PARITY(1), .CNT_BITS(CB)) u_odd (
        .clk_2(clk_2), .reset_n(reset_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_bit(in_bit), .busy(busy1), .bit_count(bc1),
        .run_parity(rp1), .par_valid(pv1), .par_bit(pb1), .frame_done(fd1),
        .parity_err(pe1), .err_count(ec1)
    );

    typedef struct {
        logic          m;
        logic          val;
        logic [CB-1:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt0     = 0;
    int   cnt1     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int c);
`ifdef PARITY_ERR_CNT_EN
        return (c < (1 << CB) - 1) ? c + 1 : c;
`else
        return 0;
`endif
    endfunction

    // Compare one instance's pulses against the oldest expected frame result.
    task automatic mon(input int idx, input logic fd, input logic pv, input logic pb,
                       input logic pe, input logic [CB-1:0] ec);
        exp_t e;
        if (fd) begin
            if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL u%0d_unexpected_frame_done: got 1 expected 0 at %0t", idx, $time);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("u%0d_par_valid", idx), pv, !e.m);
                if (!e.m) chk($sformatf("u%0d_par_bit", idx), pb, e.val);
                chk($sformatf("u%0d_parity_err", idx), pe, e.m ? e.val : 1'b0);
                chk($sformatf("u%0d_err_count", idx), ec, e.cnt);
            end
        end else begin
            chk($sformatf("u%0d_par_valid_idle", idx), pv, 0);
            chk($sformatf("u%0d_parity_err_idle", idx), pe, 0);
        end
    endtask

    always @(negedge clk_2) begin
        if (reset_n) begin
            mon(0, fd0, pv0, pb0, pe0, ec0);
            mon(1, fd1, pv1, pb1, pe1, ec1);
        end
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic gaps(input int n);
        repeat (n) begin
            mode = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_bit(input logic b, input logic m);
        in_valid = 1'b1;
        in_bit   = b;
        mode     = m;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        mode     = 1'($urandom);
    endtask

    task automatic push_gen(input logic [WB-1:0] d);
        exp_t e;
        e.m = 1'b0; e.val = ^d;  e.cnt = CB'(cnt0); q0.push_back(e);
        e.m = 1'b0; e.val = ~^d; e.cnt = CB'(cnt1); q1.push_back(e);
    endtask

    task automatic push_chk(input logic [WB-1:0] d, input logic rx);
        exp_t e;
        logic err;
        err = (^d) ^ rx;
        if (err) cnt0 = sat_inc(cnt0);
        e.m = 1'b1; e.val = err; e.cnt = CB'(cnt0); q0.push_back(e);
        if (!err) cnt1 = sat_inc(cnt1);
        e.m = 1'b1; e.val = ~err; e.cnt = CB'(cnt1); q1.push_back(e);
    endtask

    // Mode is only presented correctly on bit 1; later bits carry random mode.
    task automatic send_frame(input logic m, input logic [WB-1:0] d, input logic rx,
                              input int gmax);
        logic [WB-1:0] mk;
        for (int i = 0; i < WB; i++) begin
            gaps($urandom_range(gmax, 0));
            if (i == WB - 1 && !m) push_gen(d);
            send_bit(d[i], (i == 0) ? m : 1'($urandom));
            if (i < WB - 1 || m) begin
                mk = WB'((1 << (i + 1)) - 1);
                chk("bit_count", bc0, i + 1);
                chk("run_parity", rp0, ^(d & mk));
                chk("busy_in_frame", busy1, 1);
            end
        end
        if (m) begin
            gaps($urandom_range(gmax, 0));
            push_chk(d, rx);
            send_bit(rx, 1'($urandom));
        end
        chk("bit_count_end", bc0, 0);
        chk("run_parity_end", rp0, 0);
        chk("busy_end", busy0, 0);
    endtask

    initial begin
        logic [WB-1:0] d;
        reset_n  = 1'b0;
        clear    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_bit_count", bc0, 0);
        chk("rst_run_parity", rp0, 0);
        chk("rst_par_valid", pv0, 0);
        chk("rst_frame_done", fd1, 0);
        chk("rst_err_count", ec0, 0);
        #3 reset_n = 1'b1;
        tick();

        // Generate: bits 1,0,1,1,0,0,0,0 then all zeros (odd instance gives 1).
        send_frame(1'b0, 8'b0000_1101, 1'b0, 0);
        tick();
        send_frame(1'b0, 8'h00, 1'b0, 1);
        tick();

        // Check: data 1,1,0,... with parity 0 (pass) then parity 1 (fail).
        send_frame(1'b1, 8'b0000_0011, 1'b0, 0);
        tick();
        send_frame(1'b1, 8'b0000_0011, 1'b1, 0);
        tick();

        // Asynchronous reset after 3 bits, mid clock-high phase.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("pre_reset_bit_count", bc0, 3);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy", busy0, 0);
        chk("reset_bit_count", bc0, 0);
        chk("reset_err_count", ec0, 0);
        chk("reset_busy_odd", busy1, 0);
        cnt0 = 0;
        cnt1 = 0;
        #1 reset_n = 1'b1;
        tick();
        send_frame(1'b1, 8'hA5, 1'b1, 0);

        // Back-to-back: next frame's first bit in the frame_done cycle.
        send_frame(1'b0, 8'h3C, 1'b0, 0);
        send_frame(1'b1, 8'h81, 1'b0, 0);
        send_frame(1'b0, 8'h7E, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            d = WB'($urandom);
            send_frame(1'($urandom), d, 1'($urandom), 3);
            gaps($urandom_range(2, 0));
        end

        // Clear after 5 bits, asserted together with a valid bit.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", busy0, 0);
        chk("clear_bit_count", bc0, 0);
        chk("clear_run_parity", rp0, 0);
        chk("clear_err_count", ec0, CB'(cnt0));
        gaps(2);
        send_frame(1'b0, 8'h11, 1'b0, 0);

        // 300 frames failing on the even instance.
        for (int k = 0; k < 300; k++) begin
            d = WB'($urandom);
            send_frame(1'b1, d, ~(^d), 0);
        end
        gaps(3);
`ifdef PARITY_ERR_CNT_EN
        chk("sat_err_count", ec0, (1 << CB) - 1);
`else
        chk("nocnt_err_count", ec0, 0);
`endif
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_framer.md
SERIAL_PARITY_FRAMER -- requirements
Module: serial_parity_framer

Interface
REQ-001 SHALL have parameter WORD_BITS, default 8, data bits per frame, legal range 2..32.
REQ-002 SHALL have parameter ODD_PARITY, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have parameter CNT_BITS, default 8, width of the error counter.
REQ-004 SHALL have port clk_2  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  in  1  synchronous frame abort.
REQ-007 SHALL have port mode  in  1  0 = generate parity, 1 = check received parity; sampled on the first bit of a frame.
REQ-008 SHALL have port in_valid  in  1  qualifies in_bit this cycle.
REQ-009 SHALL have port in_bit  in  1  serial data or parity bit.
REQ-010 SHALL have port busy  out  1  frame in progress (state != IDLE).
REQ-011 SHALL have port bit_count  out  $clog2(WORD_BITS+1)  data bits accepted in the current frame.
REQ-012 SHALL have port run_parity  out  1  XOR of the data bits accepted in the current frame.
REQ-013 SHALL have port par_valid  out  1  one-cycle pulse; par_bit is valid (generate mode).
REQ-014 SHALL have port par_bit  out  1  computed parity bit.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at frame end (both modes).
REQ-016 SHALL have port parity_err  out  1  one-cycle pulse with frame_done on a check failure.
REQ-017 SHALL have port err_count  out  CNT_BITS  saturating count of check failures.

Function
REQ-018 SHALL implement states IDLE, DATA and CHKPAR.
REQ-019 IDLE: on in_valid, SHALL latch mode, load acc=in_bit and bit_count=1, and go to DATA (to CHKPAR/complete per REQ-020/021 when WORD_BITS reached).
REQ-020 DATA: each in_valid SHALL XOR in_bit into acc and increment bit_count; cycles without in_valid SHALL hold all state.
REQ-021 On accepting data bit number WORD_BITS in generate mode, the FSM SHALL go to IDLE; in the next cycle par_valid=1, frame_done=1 and par_bit=acc^ODD_PARITY (1-cycle latency).
REQ-022 On accepting data bit number WORD_BITS in check mode, the FSM SHALL go to CHKPAR with bit_count=WORD_BITS.
REQ-023 CHKPAR: the next in_valid bit is the received parity rx; the FSM SHALL go to IDLE, and the next cycle SHALL show frame_done=1 and parity_err=acc^rx^ODD_PARITY.
REQ-024 On each frame completion the design SHALL clear acc and bit_count, so run_parity=0 and bit_count=0 in IDLE.
REQ-025 In the frame_done cycle the FSM is in IDLE, so an in_valid in that cycle SHALL be accepted as bit 1 of the next frame (back-to-back, no bubble).
REQ-026 par_valid SHALL never assert in check mode; parity_err SHALL never assert in generate mode.
REQ-027 A change of mode mid-frame SHALL be ignored until the next frame's first bit.
REQ-028 clear SHALL have priority over in_valid: go to IDLE, acc=0, bit_count=0, no pulses next cycle; err_count is unaffected.
REQ-029 err_count SHALL increment on each parity_err pulse and saturate at 2^CNT_BITS-1.

Reset
REQ-030 reset_n=0 SHALL immediately force state=IDLE and all outputs to 0, including err_count, regardless of the clock or an in-progress frame.
REQ-031 The first in_valid after reset_n rises SHALL be treated as bit 1 of a frame.

Configuration
REQ-032 Macro PARITY_ERR_CNT_EN defined: err_count SHALL behave per REQ-029.
REQ-033 Macro PARITY_ERR_CNT_EN undefined: the counter SHALL not be built and err_count SHALL be constant 0; all other behaviour is unchanged.

Verification (WORD_BITS=8, ODD_PARITY=0, CNT_BITS=8, PARITY_ERR_CNT_EN defined unless noted)
REQ-034 Reset mid-frame: reset_n=0 after 3 bits -> busy=0 and bit_count=0 at once; next frame is counted from 1.
REQ-035 Generate: mode=0, bits 1,0,1,1,0,0,0,0 -> cycle after the 8th bit: par_valid=1, par_bit=1, frame_done=1; with ODD_PARITY=1 and all-zero bits -> par_bit=1.
REQ-036 Check pass/fail: mode=1, data 1,1,0,0,0,0,0,0 then parity 0 -> frame_done=1, parity_err=0, err_count=0; parity 1 -> parity_err=1, err_count=1.
REQ-037 Saturation: 300 failing frames -> err_count=255 and holds; with the macro undefined -> err_count=0 throughout.
REQ-038 Gaps, back-to-back and clear: random in_valid gaps give the same results; a bit in the frame_done cycle -> bit_count=1 next cycle; clear after 5 bits -> IDLE, no par_valid, err_count unchanged.
